// File: rtl/perf_counter_unit_if.sv
// Counter-unit bus: retire strobe and CSR write port in, counter/inhibit state out.
// The master drives stimulus; the counter unit attaches as the slave.
interface perf_counter_unit_if #(
  parameter int DWidth = 32,
  parameter int AWidth = 12
);
  logic                  retire_i;
  logic [AWidth-1:0]     csr_waddr_i;
  logic [DWidth-1:0]     csr_wdata_i;
  logic                  csr_we_i;
  logic [2*DWidth-1:0]   cycle_o;
  logic [2*DWidth-1:0]   instret_o;
  logic [DWidth-1:0]     inhibit_o;

  modport master (
    output retire_i, csr_waddr_i, csr_wdata_i, csr_we_i,
    input  cycle_o, instret_o, inhibit_o
  );

  modport slave (
    input  retire_i, csr_waddr_i, csr_wdata_i, csr_we_i,
    output cycle_o, instret_o, inhibit_o
  );
endinterface

// File: rtl/perf_counter_unit.sv
// 64-bit mcycle/minstret counters with CSR half-word preset.
// Optional mcountinhibit register enabled by macro PERF_COUNTER_INHIBIT_EN.
module perf_counter_unit #(
  parameter int DWidth = 32,
  parameter int AWidth = 12
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  perf_counter_unit_if.slave     bus
);
  localparam int CWidth = 2 * DWidth;

  localparam logic [AWidth-1:0] ADDR_MCYCLE    = AWidth'(12'hB00);
  localparam logic [AWidth-1:0] ADDR_MINSTRET  = AWidth'(12'hB02);
  localparam logic [AWidth-1:0] ADDR_MCYCLEH   = AWidth'(12'hB80);
  localparam logic [AWidth-1:0] ADDR_MINSTRETH = AWidth'(12'hB82);

  // Index 0 is mcycle, index 1 is minstret.
  localparam logic [1:0][AWidth-1:0] LO_ADDR = {ADDR_MINSTRET,  ADDR_MCYCLE};
  localparam logic [1:0][AWidth-1:0] HI_ADDR = {ADDR_MINSTRETH, ADDR_MCYCLEH};

  logic [1:0] inhibit_bits;   // [0]=CY, [1]=IR
  logic [1:0] inc_en;

  assign inc_en[0] = ~inhibit_bits[0];
  assign inc_en[1] = ~inhibit_bits[1] & bus.retire_i;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : gen_cnt
      logic [CWidth-1:0] cnt_reg;
      logic [CWidth-1:0] cnt_next;
      logic              wr_lo;
      logic              wr_hi;

      assign wr_lo = bus.csr_we_i && (bus.csr_waddr_i == LO_ADDR[gi]);
      assign wr_hi = bus.csr_we_i && (bus.csr_waddr_i == HI_ADDR[gi]);

      // A half write freezes the other half: no increment, no carry that cycle.
      always_comb begin
        cnt_next = cnt_reg;
        if (wr_lo) begin
          cnt_next = {cnt_reg[CWidth-1:DWidth], bus.csr_wdata_i};
        end else if (wr_hi) begin
          cnt_next = {bus.csr_wdata_i, cnt_reg[DWidth-1:0]};
        end else if (inc_en[gi]) begin
          cnt_next = cnt_reg + CWidth'(1);
        end
      end

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          cnt_reg <= '0;
        end else begin
          cnt_reg <= cnt_next;
        end
      end
    end
  endgenerate

  assign bus.cycle_o   = gen_cnt[0].cnt_reg;
  assign bus.instret_o = gen_cnt[1].cnt_reg;

`ifdef PERF_COUNTER_INHIBIT_EN
  localparam logic [AWidth-1:0] ADDR_MCOUNTINHIBIT = AWidth'(12'h320);

  logic [1:0] inhibit_reg;

  // The write cycle's increment decision sees the old inhibit value.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      inhibit_reg <= '0;
    end else if (bus.csr_we_i && (bus.csr_waddr_i == ADDR_MCOUNTINHIBIT)) begin
      inhibit_reg <= {bus.csr_wdata_i[2], bus.csr_wdata_i[0]};
    end
  end

  assign inhibit_bits = inhibit_reg;

  for (gi = 0; gi < DWidth; gi++) begin : gen_inh
    if (gi == 0) begin : gen_cy
      assign bus.inhibit_o[gi] = inhibit_reg[0];
    end else if (gi == 2) begin : gen_ir
      assign bus.inhibit_o[gi] = inhibit_reg[1];
    end else begin : gen_zero
      assign bus.inhibit_o[gi] = 1'b0;
    end
  end
`else
  assign inhibit_bits  = 2'b00;
  assign bus.inhibit_o = '0;
`endif

endmodule

// File: tb/tb_perf_counter_unit.sv
// Self-checking bench for perf_counter_unit: directed scenarios plus a randomized
// run compared against a whole-counter arithmetic reference model.
module tb_perf_counter_unit;
  logic clk;
  logic rst;

  perf_counter_unit_if #(.DWidth(32), .AWidth(12)) bus ();

  perf_counter_unit #(.DWidth(32), .AWidth(12)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Reference state
  logic [63:0] m_cycle;
  logic [63:0] m_instret;
  logic [31:0] m_inh;

`ifdef PERF_COUNTER_INHIBIT_EN
  localparam bit INH_EN = 1'b1;
`else
  localparam bit INH_EN = 1'b0;
`endif

  // Drive one cycle of inputs, advance one edge, update the model, settle.
  task automatic step(input logic r, input logic we, input logic [11:0] a,
                      input logic [31:0] d, input logic ret);
    logic [31:0] old_inh;
    rst             = r;
    bus.csr_we_i    = we;
    bus.csr_waddr_i = a;
    bus.csr_wdata_i = d;
    bus.retire_i    = ret;
    @(posedge clk);
    if (r) begin
      m_cycle   = 64'd0;
      m_instret = 64'd0;
      m_inh     = 32'd0;
    end else begin
      old_inh = m_inh;
      if (we && a == 12'hB00)      m_cycle = {m_cycle[63:32], d};
      else if (we && a == 12'hB80) m_cycle = {d, m_cycle[31:0]};
      else if (!old_inh[0])        m_cycle = m_cycle + 64'd1;
      if (we && a == 12'hB02)      m_instret = {m_instret[63:32], d};
      else if (we && a == 12'hB82) m_instret = {d, m_instret[31:0]};
      else if (!old_inh[2] && ret) m_instret = m_instret + 64'd1;
      if (INH_EN && we && a == 12'h320) m_inh = {29'd0, d[2], 1'b0, d[0]};
      if (we) $display("t=%0t write addr=%h data=%h retire=%0b", $time, a, d, ret);
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 12'h000, 32'd0, 1'b0);
  endtask

  task automatic test_reset;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 12'h000, 32'd0, 1'b0);
    total_cnt++;
    if (bus.cycle_o !== 64'd0) $display("FAIL reset_cycle got=%h exp=0", bus.cycle_o);
    else pass_cnt++;
    total_cnt++;
    if (bus.instret_o !== 64'd0) $display("FAIL reset_instret got=%h exp=0", bus.instret_o);
    else pass_cnt++;
    total_cnt++;
    if (bus.inhibit_o !== 32'd0) $display("FAIL reset_inhibit got=%h exp=0", bus.inhibit_o);
    else pass_cnt++;
    idle(10);
    total_cnt++;
    if (bus.cycle_o !== 64'd10) $display("FAIL idle10_cycle got=%h exp=%h", bus.cycle_o, 64'd10);
    else pass_cnt++;
    total_cnt++;
    if (bus.instret_o !== 64'd0) $display("FAIL idle10_instret got=%h exp=0", bus.instret_o);
    else pass_cnt++;
  endtask

  task automatic test_low_write_carry;
    step(1'b0, 1'b1, 12'hB00, 32'hFFFF_FFFF, 1'b0);
    total_cnt++;
    if (bus.cycle_o !== 64'h0000_0000_FFFF_FFFF)
      $display("FAIL lo_write got=%h exp=%h", bus.cycle_o, 64'h0000_0000_FFFF_FFFF);
    else pass_cnt++;
    idle(1);
    total_cnt++;
    if (bus.cycle_o !== 64'h0000_0001_0000_0000)
      $display("FAIL lo_carry got=%h exp=%h", bus.cycle_o, 64'h0000_0001_0000_0000);
    else pass_cnt++;
    idle(1);
    total_cnt++;
    if (bus.cycle_o !== m_cycle) $display("FAIL lo_carry_next got=%h exp=%h", bus.cycle_o, m_cycle);
    else pass_cnt++;
  endtask

  task automatic test_high_write_retire;
    step(1'b0, 1'b1, 12'hB82, 32'd0, 1'b0);
    step(1'b0, 1'b1, 12'hB02, 32'd5, 1'b0);
    total_cnt++;
    if (bus.instret_o !== 64'd5) $display("FAIL instret_preset got=%h exp=5", bus.instret_o);
    else pass_cnt++;
    step(1'b0, 1'b1, 12'hB82, 32'h1234, 1'b1);
    total_cnt++;
    if (bus.instret_o !== 64'h0000_1234_0000_0005)
      $display("FAIL hi_write_retire got=%h exp=%h", bus.instret_o, 64'h0000_1234_0000_0005);
    else pass_cnt++;
    total_cnt++;
    if (bus.cycle_o !== m_cycle) $display("FAIL other_counter got=%h exp=%h", bus.cycle_o, m_cycle);
    else pass_cnt++;
    step(1'b0, 1'b0, 12'h000, 32'd0, 1'b1);
    total_cnt++;
    if (bus.instret_o !== 64'h0000_1234_0000_0006)
      $display("FAIL retire_after got=%h exp=%h", bus.instret_o, 64'h0000_1234_0000_0006);
    else pass_cnt++;
  endtask

  task automatic test_wrap;
    step(1'b0, 1'b1, 12'hB80, 32'hFFFF_FFFF, 1'b0);
    step(1'b0, 1'b1, 12'hB00, 32'hFFFF_FFFE, 1'b0);
    total_cnt++;
    if (bus.cycle_o !== 64'hFFFF_FFFF_FFFF_FFFE)
      $display("FAIL wrap_preset got=%h exp=%h", bus.cycle_o, 64'hFFFF_FFFF_FFFF_FFFE);
    else pass_cnt++;
    idle(1);
    total_cnt++;
    if (bus.cycle_o !== 64'hFFFF_FFFF_FFFF_FFFF)
      $display("FAIL wrap_max got=%h exp=%h", bus.cycle_o, 64'hFFFF_FFFF_FFFF_FFFF);
    else pass_cnt++;
    idle(1);
    total_cnt++;
    if (bus.cycle_o !== 64'd0) $display("FAIL wrap_zero got=%h exp=0", bus.cycle_o);
    else pass_cnt++;
  endtask

  task automatic test_inhibit;
    logic [63:0] c0, i0;
    step(1'b0, 1'b1, 12'h320, 32'hFFFF_FFFF & 32'h5, 1'b1);
    c0 = m_cycle;
    i0 = m_instret;
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 12'h000, 32'd0, 1'b1);
    total_cnt++;
    if (bus.inhibit_o !== (INH_EN ? 32'h5 : 32'h0))
      $display("FAIL inhibit_val got=%h exp=%h", bus.inhibit_o, INH_EN ? 32'h5 : 32'h0);
    else pass_cnt++;
    total_cnt++;
    if (bus.cycle_o !== (INH_EN ? c0 : c0 + 64'd4))
      $display("FAIL inhibit_cycle got=%h exp=%h", bus.cycle_o, INH_EN ? c0 : c0 + 64'd4);
    else pass_cnt++;
    total_cnt++;
    if (bus.instret_o !== (INH_EN ? i0 : i0 + 64'd4))
      $display("FAIL inhibit_instret got=%h exp=%h", bus.instret_o, INH_EN ? i0 : i0 + 64'd4);
    else pass_cnt++;
    step(1'b0, 1'b1, 12'h320, 32'd0, 1'b1);
    step(1'b0, 1'b0, 12'h000, 32'd0, 1'b1);
    step(1'b0, 1'b0, 12'h000, 32'd0, 1'b1);
    total_cnt++;
    if (bus.cycle_o !== m_cycle) $display("FAIL resume_cycle got=%h exp=%h", bus.cycle_o, m_cycle);
    else pass_cnt++;
    total_cnt++;
    if (bus.instret_o !== m_instret) $display("FAIL resume_instret got=%h exp=%h", bus.instret_o, m_instret);
    else pass_cnt++;
    total_cnt++;
    if (bus.inhibit_o !== 32'd0) $display("FAIL resume_inhibit got=%h exp=0", bus.inhibit_o);
    else pass_cnt++;
  endtask

  task automatic test_reset_override;
    step(1'b0, 1'b1, 12'hB80, 32'd0, 1'b0);
    step(1'b0, 1'b1, 12'hB00, 32'h77, 1'b0);
    step(1'b0, 1'b1, 12'h320, 32'h5, 1'b1);
    step(1'b1, 1'b1, 12'hB00, 32'hDEAD_BEEF, 1'b1);
    total_cnt++;
    if (bus.cycle_o !== 64'd0) $display("FAIL rst_over_cycle got=%h exp=0", bus.cycle_o);
    else pass_cnt++;
    total_cnt++;
    if (bus.instret_o !== 64'd0) $display("FAIL rst_over_instret got=%h exp=0", bus.instret_o);
    else pass_cnt++;
    total_cnt++;
    if (bus.inhibit_o !== 32'd0) $display("FAIL rst_over_inhibit got=%h exp=0", bus.inhibit_o);
    else pass_cnt++;
  endtask

  task automatic test_random;
    logic [11:0] addrs [6];
    logic [11:0] a;
    logic        we, ret, r;
    logic [31:0] d;
    addrs[0] = 12'hB00; addrs[1] = 12'hB80; addrs[2] = 12'hB02;
    addrs[3] = 12'hB82; addrs[4] = 12'h320; addrs[5] = 12'hB01;
    for (int i = 0; i < 400; i++) begin
      r   = ($urandom_range(0, 63) == 0);
      we  = ($urandom_range(0, 3) == 0);
      a   = ($urandom_range(0, 7) < 6) ? addrs[$urandom_range(0, 5)] : 12'($urandom);
      ret = $urandom_range(0, 1) == 1;
      d   = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 3)) : $urandom;
      step(r, we, a, d, ret);
      total_cnt++;
      if (bus.cycle_o !== m_cycle) $display("FAIL rnd_cycle i=%0d got=%h exp=%h", i, bus.cycle_o, m_cycle);
      else pass_cnt++;
      total_cnt++;
      if (bus.instret_o !== m_instret) $display("FAIL rnd_instret i=%0d got=%h exp=%h", i, bus.instret_o, m_instret);
      else pass_cnt++;
      total_cnt++;
      if (bus.inhibit_o !== m_inh) $display("FAIL rnd_inhibit i=%0d got=%h exp=%h", i, bus.inhibit_o, m_inh);
      else pass_cnt++;
    end
  endtask

  initial begin
    rst             = 1'b1;
    bus.csr_we_i    = 1'b0;
    bus.csr_waddr_i = 12'h000;
    bus.csr_wdata_i = 32'd0;
    bus.retire_i    = 1'b0;
    m_cycle         = 64'd0;
    m_instret       = 64'd0;
    m_inh           = 32'd0;
    test_reset;
    test_low_write_carry;
    test_high_write_retire;
    test_wrap;
    test_inhibit;
    test_reset_override;
    test_random;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
